// File: rtl/operand_collector.sv
// Eight-entry operand collector: issue allocates an entry, four bank read ports fill
// up to three operand slots, and complete entries leave through a round-robin dispatch port.
module operand_collector #(
  parameter int NUM_OC = 8,
  parameter int DATA_W = 256,
  parameter int TAG_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [TAG_W-1:0]       alloc_tag,
  input  logic [2:0]             alloc_src_mask,
  output logic [2:0]             alloc_ocid,
  input  logic [3:0]             rsp_valid,
  input  logic [3:0][2:0]        rsp_ocid,
  input  logic [3:0][1:0]        rsp_slot,
  input  logic [3:0][DATA_W-1:0] rsp_data,
  output logic                   disp_valid,
  input  logic                   disp_ready,
  output logic [2:0]             disp_ocid,
  output logic [TAG_W-1:0]       disp_tag,
  output logic [DATA_W-1:0]      disp_src0,
  output logic [DATA_W-1:0]      disp_src1,
  output logic [DATA_W-1:0]      disp_src2,
  output logic [3:0]             occupancy,
  output logic                   err
);
  localparam int NB = 4;

  logic [NUM_OC-1:0]                   valid_vec;
  logic [NUM_OC-1:0]                   complete_vec;
  logic [NUM_OC-1:0][TAG_W-1:0]        tag_vec;
  logic [NUM_OC-1:0][2:0]              need_vec;
  logic [NUM_OC-1:0][2:0]              have_vec;
  logic [NUM_OC-1:0][2:0][DATA_W-1:0]  op_vec;
  logic [2:0] rr_reg;
  logic [2:0] grant;
  logic       err_reg;
  logic       err_set;
  logic       alloc_fire;
  logic       disp_fire;

  // Lowest-numbered free entry; an entry freed this cycle is still marked valid.
  always_comb begin
    alloc_ocid = '0;
    for (int i = NUM_OC - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_ocid = 3'(i);
    end
  end

  assign alloc_ready = ~&valid_vec;
  assign alloc_fire  = alloc_valid & alloc_ready;

  always_comb begin
    logic [2:0] idx;
    idx        = '0;
    grant      = '0;
    disp_valid = 1'b0;
    for (int i = 0; i < NUM_OC; i++) begin
      idx = rr_reg + 3'(i);
      if (!disp_valid && complete_vec[idx]) begin
        grant      = idx;
        disp_valid = 1'b1;
      end
    end
  end

  assign disp_fire = disp_valid & disp_ready;
  assign disp_ocid = grant;
  assign disp_tag  = disp_valid ? tag_vec[grant]   : '0;
  assign disp_src0 = disp_valid ? op_vec[grant][0] : '0;
  assign disp_src1 = disp_valid ? op_vec[grant][1] : '0;
  assign disp_src2 = disp_valid ? op_vec[grant][2] : '0;

  // Protocol errors: ignored responses, duplicate fills and same-slot bank collisions.
  always_comb begin
    logic [2:0] e;
    logic [1:0] s;
    logic [3:0] need4;
    logic [3:0] have4;
    e       = '0;
    s       = '0;
    need4   = '0;
    have4   = '0;
    err_set = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (rsp_valid[b]) begin
        e     = rsp_ocid[b];
        s     = rsp_slot[b];
        need4 = {1'b0, need_vec[e]};
        have4 = {1'b0, have_vec[e]};
        if (!valid_vec[e] || !need4[s] || have4[s]) err_set = 1'b1;
        for (int c = 0; c < b; c++) begin
          if (rsp_valid[c] && rsp_ocid[c] == e && rsp_slot[c] == s) err_set = 1'b1;
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_OC; i++) occupancy = occupancy + 4'(valid_vec[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      if (disp_fire) rr_reg <= grant + 3'd1;
      if (err_set)   err_reg <= 1'b1;
    end
  end

  assign err = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OC; gi++) begin : g_entry
      logic                    valid_reg;
      logic [TAG_W-1:0]        tag_reg;
      logic [2:0]              need_reg;
      logic [2:0]              have_reg;
      logic [2:0][DATA_W-1:0]  op_reg;
      logic [2:0]              hit;
      logic [2:0][DATA_W-1:0]  hit_data;

      // Per slot, the lowest-indexed bank addressing it wins.
      always_comb begin
        hit      = '0;
        hit_data = '0;
        for (int k = 0; k < 3; k++) begin
          for (int b = NB - 1; b >= 0; b--) begin
            if (rsp_valid[b] && rsp_ocid[b] == 3'(gi) && rsp_slot[b] == 2'(k)) begin
              hit[k]      = 1'b1;
              hit_data[k] = rsp_data[b];
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          need_reg  <= '0;
          have_reg  <= '0;
          op_reg    <= '0;
        end else if (alloc_fire && alloc_ocid == 3'(gi)) begin
          valid_reg <= 1'b1;
          tag_reg   <= alloc_tag;
          need_reg  <= alloc_src_mask;
          have_reg  <= '0;
          op_reg    <= '0;
        end else if (valid_reg) begin
          if (disp_fire && grant == 3'(gi)) valid_reg <= 1'b0;
          for (int k = 0; k < 3; k++) begin
            if (hit[k] && need_reg[k]) begin
              op_reg[k]   <= hit_data[k];
              have_reg[k] <= 1'b1;
            end
          end
        end
      end

      assign valid_vec[gi]    = valid_reg;
      assign tag_vec[gi]      = tag_reg;
      assign need_vec[gi]     = need_reg;
      assign have_vec[gi]     = have_reg;
      assign op_vec[gi]       = op_reg;
      assign complete_vec[gi] = valid_reg && (have_reg == need_reg);
    end
  endgenerate

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: a per-cycle behavioural model predicts
// allocation, capture and dispatch; a monitor checks each dispatch handshake.
module tb_operand_collector;
  localparam int NOC = 8;
  localparam int DW  = 256;
  localparam int TW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               alloc_valid;
  logic               alloc_ready;
  logic [TW-1:0]      alloc_tag;
  logic [2:0]         alloc_src_mask;
  logic [2:0]         alloc_ocid;
  logic [3:0]         rsp_valid;
  logic [3:0][2:0]    rsp_ocid;
  logic [3:0][1:0]    rsp_slot;
  logic [3:0][DW-1:0] rsp_data;
  logic               disp_valid;
  logic               disp_ready;
  logic [2:0]         disp_ocid;
  logic [TW-1:0]      disp_tag;
  logic [DW-1:0]      disp_src0;
  logic [DW-1:0]      disp_src1;
  logic [DW-1:0]      disp_src2;
  logic [3:0]         occupancy;
  logic               err;

  operand_collector #(.NUM_OC(NOC), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_src_mask(alloc_src_mask), .alloc_ocid(alloc_ocid),
    .rsp_valid(rsp_valid), .rsp_ocid(rsp_ocid), .rsp_slot(rsp_slot), .rsp_data(rsp_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_ocid(disp_ocid),
    .disp_tag(disp_tag), .disp_src0(disp_src0), .disp_src1(disp_src1),
    .disp_src2(disp_src2), .occupancy(occupancy), .err(err)
  );

  // Reference model state
  logic          m_valid [NOC];
  logic [TW-1:0] m_tag   [NOC];
  logic [2:0]    m_need  [NOC];
  logic [2:0]    m_have  [NOC];
  logic [DW-1:0] m_op    [NOC][3];
  int            m_rr;
  logic          m_err;

  typedef struct {
    logic [2:0]    ocid;
    logic [TW-1:0] tag;
    logic [DW-1:0] s0;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
  } disp_t;
  disp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NOC; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_need[i]  = '0;
      m_have[i]  = '0;
      for (int k = 0; k < 3; k++) m_op[i][k] = '0;
    end
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  function automatic int model_grant();
    for (int i = 0; i < NOC; i++) begin
      int e;
      e = (m_rr + i) % NOC;
      if (m_valid[e] && m_have[e] == m_need[e]) return e;
    end
    return -1;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < NOC; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic idle_inputs();
    alloc_valid    = 1'b0;
    alloc_tag      = '0;
    alloc_src_mask = '0;
    rsp_valid      = '0;
    rsp_ocid       = '0;
    rsp_slot       = '0;
    rsp_data       = '0;
    disp_ready     = 1'b0;
  endtask

  // Inputs are already driven (just after a negedge). Check, predict, advance the model.
  task automatic cycle();
    int    g, f, occ;
    bit    taken [NOC][4];
    disp_t d;
    #1;
    g   = model_grant();
    f   = model_free();
    occ = 0;
    for (int i = 0; i < NOC; i++) if (m_valid[i]) occ++;
    check_v("alloc_ready", 32'(alloc_ready), 32'(f >= 0));
    if (f >= 0) check_v("alloc_ocid", 32'(alloc_ocid), 32'(f));
    check_v("occupancy", 32'(occupancy), 32'(occ));
    check_v("err", 32'(err), 32'(m_err));
    check_v("disp_valid", 32'(disp_valid), 32'(g >= 0));
    if (g >= 0 && disp_ready) begin
      d.ocid = 3'(g);
      d.tag  = m_tag[g];
      d.s0   = m_op[g][0];
      d.s1   = m_op[g][1];
      d.s2   = m_op[g][2];
      exp_q.push_back(d);
    end
    for (int e = 0; e < NOC; e++) for (int s = 0; s < 4; s++) taken[e][s] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (rsp_valid[b]) begin
        int e, s;
        e = int'(rsp_ocid[b]);
        s = int'(rsp_slot[b]);
        if (s == 3 || !m_valid[e] || !m_need[e][s]) m_err = 1'b1;
        else if (taken[e][s]) m_err = 1'b1;
        else begin
          taken[e][s] = 1'b1;
          if (m_have[e][s]) m_err = 1'b1;
          m_have[e][s] = 1'b1;
          m_op[e][s]   = rsp_data[b];
        end
      end
    end
    if (g >= 0 && disp_ready) begin
      m_valid[g] = 1'b0;
      m_rr       = (g + 1) % NOC;
    end
    if (alloc_valid && f >= 0) begin
      m_valid[f] = 1'b1;
      m_tag[f]   = alloc_tag;
      m_need[f]  = alloc_src_mask;
      m_have[f]  = '0;
      for (int k = 0; k < 3; k++) m_op[f][k] = '0;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_v({tag, "_alloc_ready"}, 32'(alloc_ready), 32'd1);
    check_v({tag, "_alloc_ocid"}, 32'(alloc_ocid), 32'd0);
    check_v({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check_v({tag, "_disp_ocid"}, 32'(disp_ocid), 32'd0);
    check_v({tag, "_disp_tag"}, 32'(disp_tag), 32'd0);
    check_d({tag, "_disp_src0"}, disp_src0, '0);
    check_d({tag, "_disp_src1"}, disp_src1, '0);
    check_d({tag, "_disp_src2"}, disp_src2, '0);
    check_v({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check_v({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic [2:0] mask, input logic [TW-1:0] tag);
    idle_inputs();
    alloc_valid    = 1'b1;
    alloc_src_mask = mask;
    alloc_tag      = tag;
    cycle();
  endtask

  task automatic rand_phase(input int ncyc, input bit wild);
    for (int n = 0; n < ncyc; n++) begin
      bit used [NOC][3];
      for (int e = 0; e < NOC; e++) for (int s = 0; s < 3; s++) used[e][s] = 1'b0;
      alloc_valid    = ($urandom_range(0, 99) < 40);
      alloc_tag      = TW'($urandom_range(0, 255));
      alloc_src_mask = 3'($urandom_range(0, 7));
      disp_ready     = ($urandom_range(0, 99) < 60);
      for (int b = 0; b < 4; b++) begin
        rsp_valid[b] = 1'b0;
        rsp_ocid[b]  = '0;
        rsp_slot[b]  = '0;
        rsp_data[b]  = rand_word();
        if ($urandom_range(0, 99) < 50) begin
          if (wild && $urandom_range(0, 3) == 0) begin
            rsp_valid[b] = 1'b1;
            rsp_ocid[b]  = 3'($urandom_range(0, 7));
            rsp_slot[b]  = 2'($urandom_range(0, 3));
          end else begin
            int cnt, pick;
            cnt = 0;
            for (int e = 0; e < NOC; e++)
              for (int s = 0; s < 3; s++)
                if (m_valid[e] && m_need[e][s] && !m_have[e][s] && !used[e][s]) cnt++;
            if (cnt > 0) begin
              pick = $urandom_range(0, cnt - 1);
              for (int e = 0; e < NOC; e++)
                for (int s = 0; s < 3; s++)
                  if (m_valid[e] && m_need[e][s] && !m_have[e][s] && !used[e][s]) begin
                    if (pick == 0) begin
                      rsp_valid[b] = 1'b1;
                      rsp_ocid[b]  = 3'(e);
                      rsp_slot[b]  = 2'(s);
                      if (!wild) used[e][s] = 1'b1;
                    end
                    pick--;
                  end
            end
          end
        end
      end
      cycle();
    end
  endtask

  // Monitor: whenever the DUT completes a dispatch handshake, pop and compare.
  initial begin
    disp_t d;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && disp_valid === 1'b1 && disp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dispatch_unexpected: got ocid %0d required no dispatch", disp_ocid);
        end else begin
          d = exp_q.pop_front();
          check_v("disp_ocid", 32'(disp_ocid), 32'(d.ocid));
          check_v("disp_tag", 32'(disp_tag), 32'(d.tag));
          check_d("disp_src0", disp_src0, d.s0);
          check_d("disp_src1", disp_src1, d.s1);
          check_d("disp_src2", disp_src2, d.s2);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] pat_a, pat_5;
    pat_a = {32{8'hAA}};
    pat_5 = {32{8'h55}};
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Three allocations then a same-cycle two-bank fill of OCID1
    alloc(3'b111, 8'h10);
    alloc(3'b011, 8'h11);
    alloc(3'b001, 8'h12);
    idle_inputs();
    rsp_valid   = 4'b0101;
    rsp_ocid[0] = 3'd1; rsp_slot[0] = 2'd0; rsp_data[0] = pat_a;
    rsp_ocid[2] = 3'd1; rsp_slot[2] = 2'd1; rsp_data[2] = pat_5;
    cycle();
    idle_inputs();
    cycle();
    disp_ready = 1'b1;
    cycle();
    check_v("rr_after_ocid1", 32'(m_rr), 32'd2);

    // Bank1 and bank3 collide on OCID2 slot 0; then stray responses
    idle_inputs();
    rsp_valid   = 4'b1010;
    rsp_ocid[1] = 3'd2; rsp_slot[1] = 2'd0; rsp_data[1] = pat_5;
    rsp_ocid[3] = 3'd2; rsp_slot[3] = 2'd0; rsp_data[3] = pat_a;
    cycle();
    idle_inputs();
    rsp_valid   = 4'b0011;
    rsp_ocid[0] = 3'd5; rsp_slot[0] = 2'd0; rsp_data[0] = pat_a;
    rsp_ocid[1] = 3'd0; rsp_slot[1] = 2'd3; rsp_data[1] = pat_a;
    disp_ready  = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Fill to capacity with mask 000, then drain
    do_reset();
    for (int i = 0; i < NOC; i++) alloc(3'b000, TW'(8'h40 + i));
    alloc(3'b000, 8'h7F);
    idle_inputs();
    disp_ready = 1'b1;
    for (int i = 0; i < NOC + 2; i++) cycle();

    // Two complete entries held under stall, then released
    do_reset();
    alloc(3'b000, 8'h21);
    alloc(3'b000, 8'h22);
    idle_inputs();
    for (int i = 0; i < 3; i++) cycle();
    disp_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset in the middle of collection
    do_reset();
    for (int i = 0; i < 5; i++) alloc(3'b111, TW'(8'h30 + i));
    idle_inputs();
    rsp_valid   = 4'b0011;
    rsp_ocid[0] = 3'd1; rsp_slot[0] = 2'd2; rsp_data[0] = pat_a;
    rsp_ocid[1] = 3'd3; rsp_slot[1] = 2'd0; rsp_data[1] = pat_5;
    cycle();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    alloc(3'b001, 8'h99);

    // Randomised traffic: clean protocol, then with protocol errors
    do_reset();
    rand_phase(400, 1'b0);
    check_v("err_clean", 32'(err), 32'd0);
    do_reset();
    rand_phase(400, 1'b1);

    idle_inputs();
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
